// File: rtl/crc_32_byte_pkg.sv
// -----------------------------------------------------------------------------
// crc_32_byte_pkg
// Shared definitions for the CRC-32 byte-stream checker and generator:
//   CRC_POLY          - normal (non-reflected) CRC-32 polynomial
//   CRC_INITIAL_VALUE - register seed at the start of every frame
//   crc_state_t       - checker framing FSM states
//   bit_reverse32     - mirror a 32-bit word (bit 0 <-> bit 31)
//   invert_reverse32  - final CRC transform: complement, then mirror
// -----------------------------------------------------------------------------
package crc_32_byte_pkg;

   localparam logic [31:0] CRC_POLY          = 32'h04C11DB7;
   localparam logic [31:0] CRC_INITIAL_VALUE = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2
   } crc_state_t;

   function automatic logic [31:0] bit_reverse32(input logic [31:0] value);
      logic [31:0] result;
      result = 32'h0000_0000;
      for (int i = 0; i < 32; i++) begin
         result[i] = value[31-i];
      end
      return result;
   endfunction

   function automatic logic [31:0] invert_reverse32(input logic [31:0] value);
      return bit_reverse32(~value);
   endfunction

endpackage

// File: rtl/crc_32_byte_update.sv
// -----------------------------------------------------------------------------
// crc_32_byte_update
// Combinational one-byte CRC-32 step. The register is kept in normal
// (MSB-first) orientation while data bits are consumed LSB first, which
// makes the result equal to the reflected CRC-32 once the final value is
// passed through invert_reverse32.
// Ports:
//   crc_in  [31:0] - current CRC register
//   data_in [7:0]  - byte to absorb
//   crc_out [31:0] - CRC register after absorbing data_in
// -----------------------------------------------------------------------------
module crc_32_byte_update
   import crc_32_byte_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   logic [31:0] crc_work_s;

   // Eight serial LFSR steps, data bit 0 first.
   always_comb begin
      crc_work_s = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_work_s[31] ^ data_in[i]) begin
            crc_work_s = {crc_work_s[30:0], 1'b0} ^ CRC_POLY;
         end else begin
            crc_work_s = {crc_work_s[30:0], 1'b0};
         end
      end
      crc_out = crc_work_s;
   end

endmodule

// File: rtl/crc_32_byte_checker.sv
// -----------------------------------------------------------------------------
// crc_32_byte_checker
// Receives a byte stream whose last four bytes are a CRC-32 FCS (LSB first),
// forwards the payload with the FCS stripped and reports one verdict per frame.
// A 4-byte delay line holds back the newest bytes so the FCS never reaches
// the output or the CRC.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready     - input byte stream
//   out_data/out_valid/out_last/out_ready - payload stream (registered)
//   status_valid, crc_ok, runt     - one-cycle frame verdict
//   frame_cnt, err_cnt             - saturating statistics, present only when
//                                    CRC_32_BYTE_CHECKER_STATS_EN is defined
// Parameter:
//   MIN_FRAME_BYTES - shortest accepted frame, FCS included
// -----------------------------------------------------------------------------
module crc_32_byte_checker
   import crc_32_byte_pkg::*;
#(
   parameter int MIN_FRAME_BYTES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_last,
   input  logic        out_ready,
   output logic        status_valid,
   output logic        crc_ok,
   output logic        runt
`ifdef CRC_32_BYTE_CHECKER_STATS_EN
   ,
   output logic [31:0] frame_cnt,
   output logic [31:0] err_cnt
`endif
);

   localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);

   crc_state_t  state_r;
   crc_state_t  state_next_s;
   logic [7:0]  d0_r, d1_r, d2_r, d3_r;
   logic [31:0] crc_r;
   logic [31:0] crc_next_s;
   logic [31:0] fcs_s;
   logic [15:0] len_r;
   logic [15:0] len_inc_s;
   logic        accept_s;
   logic        runt_s;
   logic        frame_ok_s;

   assign in_ready = !out_valid || out_ready;
   assign accept_s = in_valid && in_ready;

   // CRC always advances with the byte being evicted from the delay line.
   crc_32_byte_update u_update (
      .crc_in  (crc_r),
      .data_in (d0_r),
      .crc_out (crc_next_s)
   );

   // Frame length, FCS assembly and end-of-frame verdict.
   always_comb begin
      len_inc_s  = (len_r == 16'hFFFF) ? len_r : len_r + 16'd1;
      fcs_s      = {in_data, d3_r, d2_r, d1_r};
      if (state_r != ST_STREAM) begin
         runt_s = 1'b1;
      end else if (len_inc_s < MIN_LEN) begin
         runt_s = 1'b1;
      end else begin
         runt_s = 1'b0;
      end
      frame_ok_s = !runt_s && (invert_reverse32(crc_next_s) == fcs_s);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && !in_last) begin
               state_next_s = ST_FILL;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (accept_s && in_last) begin
               state_next_s = ST_IDLE;
            end else if (accept_s && (len_inc_s == 16'd4)) begin
               state_next_s = ST_STREAM;
            end else begin
               state_next_s = ST_FILL;
            end
         end
         ST_STREAM: begin
            if (accept_s && in_last) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_STREAM;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Delay line, CRC register, length counter and verdict registers.
   // Ending a frame clears everything so the next byte starts a fresh frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         d0_r         <= 8'h00;
         d1_r         <= 8'h00;
         d2_r         <= 8'h00;
         d3_r         <= 8'h00;
         crc_r        <= CRC_INITIAL_VALUE;
         len_r        <= 16'd0;
         status_valid <= 1'b0;
         crc_ok       <= 1'b0;
         runt         <= 1'b0;
      end else begin
         status_valid <= 1'b0;
         if (accept_s && in_last) begin
            d0_r         <= 8'h00;
            d1_r         <= 8'h00;
            d2_r         <= 8'h00;
            d3_r         <= 8'h00;
            crc_r        <= CRC_INITIAL_VALUE;
            len_r        <= 16'd0;
            status_valid <= 1'b1;
            crc_ok       <= frame_ok_s;
            runt         <= runt_s;
         end else if (accept_s) begin
            d0_r  <= d1_r;
            d1_r  <= d2_r;
            d2_r  <= d3_r;
            d3_r  <= in_data;
            len_r <= len_inc_s;
            if (state_r == ST_STREAM) begin
               crc_r <= crc_next_s;
            end
         end
      end
   end

   // Output register: loads the evicted byte, holds it until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept_s && (state_r == ST_STREAM)) begin
         out_data  <= d0_r;
         out_valid <= 1'b1;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

`ifdef CRC_32_BYTE_CHECKER_STATS_EN
   // Saturating frame and error counters, stepped with each verdict.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= 32'd0;
         err_cnt   <= 32'd0;
      end else if (accept_s && in_last) begin
         if (frame_cnt != 32'hFFFF_FFFF) begin
            frame_cnt <= frame_cnt + 32'd1;
         end
         if (!frame_ok_s && (err_cnt != 32'hFFFF_FFFF)) begin
            err_cnt <= err_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_crc_32_byte_checker.sv
// -----------------------------------------------------------------------------
// tb_crc_32_byte_checker
// Directed frames with hand-computed FCS bytes. The driver pushes expected
// payload bytes and verdicts into queues; a monitor on the falling edge pops
// and compares whenever the DUT presents a byte or a status pulse.
// Define CRC_32_BYTE_CHECKER_STATS_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_crc_32_byte_checker;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } out_exp_t;

   typedef struct packed {
      logic ok;
      logic runt;
   } st_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready = 1'b1;
   logic        status_valid;
   logic        crc_ok;
   logic        runt;
`ifdef CRC_32_BYTE_CHECKER_STATS_EN
   logic [31:0] frame_cnt;
   logic [31:0] err_cnt;
`endif

   out_exp_t    exp_out_q[$];
   st_exp_t     exp_st_q[$];
   out_exp_t    mon_out;
   st_exp_t     mon_st;

   int          total = 0;
   int          bad = 0;

   // Single-writer request counters from the driver to the monitor / stall process.
   int          rst_chk_req = 0;
   int          rst_chk_seen = 0;
   int          timeout_cnt = 0;
   int          timeout_seen = 0;
   int          final_req = 0;
   int          final_seen = 0;
   int          stall_req = 0;
   int          stall_seen = 0;
   int          stall_left = 0;

   logic        hold_prev = 1'b0;
   logic [7:0]  hold_data = 8'h00;
   logic        hold_last = 1'b0;
   logic        status_prev = 1'b0;

   logic [7:0]  fbuf [16];
   int          flen = 0;

   always #5 clk = ~clk;

   crc_32_byte_checker #(.MIN_FRAME_BYTES(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .status_valid (status_valid),
      .crc_ok       (crc_ok),
      .runt         (runt)
`ifdef CRC_32_BYTE_CHECKER_STATS_EN
      ,
      .frame_cnt    (frame_cnt),
      .err_cnt      (err_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // out_ready back-pressure: each stall request drops out_ready for 5 cycles.
   always @(posedge clk) begin
      #1;
      if (stall_req != stall_seen) begin
         stall_seen = stall_req;
         stall_left = 5;
      end
      if (stall_left > 0) begin
         out_ready  = 1'b0;
         stall_left = stall_left - 1;
      end else begin
         out_ready = 1'b1;
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev   = 1'b0;
         status_prev = 1'b0;
      end else begin
         if (rst_chk_req != rst_chk_seen) begin
            rst_chk_seen = rst_chk_req;
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_last", {31'd0, out_last}, 32'd0);
            check("rst_status_valid", {31'd0, status_valid}, 32'd0);
            check("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
            check("rst_runt", {31'd0, runt}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef CRC_32_BYTE_CHECKER_STATS_EN
            check("rst_frame_cnt", frame_cnt, 32'd0);
            check("rst_err_cnt", err_cnt, 32'd0);
`endif
         end
         if (timeout_cnt != timeout_seen) begin
            timeout_seen = timeout_cnt;
            check("in_ready_timeout", 32'd0, 32'd1);
         end
         if (out_valid && out_ready) begin
            if (exp_out_q.size() == 0) begin
               check("unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
               mon_out = exp_out_q.pop_front();
               check("out_data", {24'd0, out_data}, {24'd0, mon_out.data});
               check("out_last", {31'd0, out_last}, {31'd0, mon_out.last});
            end
         end
         if (hold_prev && out_valid) begin
            check("hold_out_data", {24'd0, out_data}, {24'd0, hold_data});
            check("hold_out_last", {31'd0, out_last}, {31'd0, hold_last});
         end
         if (out_valid && !out_ready) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            hold_prev = 1'b1;
            hold_data = out_data;
            hold_last = out_last;
         end else begin
            hold_prev = 1'b0;
         end
         if (status_valid) begin
            check("status_pulse_width", {31'd0, status_prev}, 32'd0);
            if (exp_st_q.size() == 0) begin
               check("unexpected_status", {30'd0, crc_ok, runt}, 32'hFFFF_FFFF);
            end else begin
               mon_st = exp_st_q.pop_front();
               check("crc_ok", {31'd0, crc_ok}, {31'd0, mon_st.ok});
               check("runt", {31'd0, runt}, {31'd0, mon_st.runt});
            end
         end
         status_prev = status_valid;
         if (final_req != final_seen) begin
            final_seen = final_req;
            check("out_queue_drained", exp_out_q.size(), 32'd0);
            check("status_queue_drained", exp_st_q.size(), 32'd0);
`ifdef CRC_32_BYTE_CHECKER_STATS_EN
            check("frame_cnt", frame_cnt, 32'd3);
            check("err_cnt", err_cnt, 32'd1);
`endif
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic last);
      int waited;
      waited   = 0;
      in_data  = b;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         timeout_cnt++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // "123456789" followed by FCS 26 39 F4 <fcs3>; CB is the correct last byte.
   task automatic load_check_frame(input logic [7:0] fcs3);
      for (int i = 0; i < 9; i++) begin
         fbuf[i] = 8'h31 + 8'(i);
      end
      fbuf[9]  = 8'h26;
      fbuf[10] = 8'h39;
      fbuf[11] = 8'hF4;
      fbuf[12] = fcs3;
      flen     = 13;
   endtask

   task automatic send_frame(input logic exp_ok, input logic exp_runt, input int stall_at);
      if (!exp_runt) begin
         for (int i = 0; i < flen - 4; i++) begin
            exp_out_q.push_back('{data: fbuf[i], last: (i == flen - 5)});
         end
      end
      exp_st_q.push_back('{ok: exp_ok, runt: exp_runt});
      for (int i = 0; i < flen; i++) begin
         if (i == stall_at) begin
            stall_req++;
         end
         send_byte(fbuf[i], (i == flen - 1));
      end
   endtask

   initial begin
      int waited;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rst_chk_req++;
      repeat (2) @(posedge clk);
      #1;

      load_check_frame(8'hCB);
      send_frame(1'b1, 1'b0, -1);
      load_check_frame(8'hCA);
      send_frame(1'b0, 1'b0, -1);

      fbuf[0] = 8'hAA; fbuf[1] = 8'hBB; fbuf[2] = 8'hCC; flen = 3;
      send_frame(1'b0, 1'b1, -1);
      fbuf[0] = 8'h11; fbuf[1] = 8'h22; fbuf[2] = 8'h33; fbuf[3] = 8'h44; flen = 4;
      send_frame(1'b0, 1'b1, -1);

      // "a": CRC-32 = E8B7BE43, shortest frame that is not a runt.
      fbuf[0] = 8'h61; fbuf[1] = 8'h43; fbuf[2] = 8'hBE; fbuf[3] = 8'hB7; fbuf[4] = 8'hE8;
      flen = 5;
      send_frame(1'b1, 1'b0, -1);

      load_check_frame(8'hCB);
      send_frame(1'b1, 1'b0, 7);
      repeat (12) @(posedge clk);
      #1;

      // Abort after 6 bytes: bytes 1 and 2 are emitted before reset.
      load_check_frame(8'hCB);
      exp_out_q.push_back('{data: fbuf[0], last: 1'b0});
      exp_out_q.push_back('{data: fbuf[1], last: 1'b0});
      for (int i = 0; i < 6; i++) begin
         send_byte(fbuf[i], 1'b0);
      end
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_data  = 8'h5A;
      in_valid = 1'b1;
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst_chk_req++;
      repeat (2) @(posedge clk);
      #1;

      load_check_frame(8'hCB);
      send_frame(1'b1, 1'b0, -1);
      send_frame(1'b1, 1'b0, -1);
      load_check_frame(8'hCA);
      send_frame(1'b0, 1'b0, -1);

      waited = 0;
      while ((exp_out_q.size() != 0 || exp_st_q.size() != 0) && waited < 200) begin
         waited++;
         @(posedge clk);
      end
      repeat (3) @(posedge clk);
      #1;
      final_req++;
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crc_32_byte_checker.md
CRC_32_BYTE_CHECKER -- requirements
Module: crc_32_byte_checker

Interface
REQ-001 SHALL have parameter MIN_FRAME_BYTES, default 5, meaning minimum accepted frame length in bytes, FCS included.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 8 bits: received byte, FCS as the last 4 bytes.
REQ-005 SHALL have ports in_valid (input, 1), in_last (input, 1), in_ready (output, 1): input handshake, last marks the final FCS byte.
REQ-006 SHALL have ports out_data (output, 8), out_valid (output, 1), out_last (output, 1), out_ready (input, 1): payload with FCS stripped.
REQ-007 SHALL have ports status_valid, crc_ok, runt (outputs, 1 bit each): per-frame verdict.
REQ-008 SHALL, with CRC_32_BYTE_CHECKER_STATS_EN defined, add outputs frame_cnt and err_cnt (32 bits each).

Function
REQ-009 SHALL use reflected CRC-32 (poly 04C11DB7, init FFFFFFFF, LSB-first byte processing, final inversion with bit reversal).
REQ-010 SHALL transfer an input byte when in_valid and in_ready are both high; in_ready = !out_valid || out_ready.
REQ-011 SHALL implement FSM IDLE -> FILL -> STREAM -> IDLE; IDLE leaves on the first accepted byte.
REQ-012 SHALL hold the newest 4 accepted bytes in a delay line d0 (oldest) to d3; FILL ends when the 4th byte is accepted without in_last.
REQ-013 SHALL, in STREAM, on each accepted byte evict d0 into the registered output, so out_valid rises the next cycle and output latency is 1 clock.
REQ-014 SHALL update the CRC register with each evicted byte only; FCS bytes never enter the CRC or the output.
REQ-015 SHALL, on in_last accepted in STREAM, set out_last with the evicted byte and assemble FCS = {in_data, d3, d2, d1}, so the first FCS byte is the LSB.
REQ-016 SHALL set crc_ok = 1 iff the bit-reversed, inverted final CRC equals the assembled FCS.
REQ-017 SHALL pulse status_valid for exactly 1 cycle, one clock after in_last is accepted, with crc_ok and runt stable in that cycle.
REQ-018 SHALL treat in_last accepted in IDLE or FILL, or a total length below MIN_FRAME_BYTES, as runt=1, crc_ok=0, with no output bytes.
REQ-019 SHALL reinitialise the CRC to FFFFFFFF and clear the delay line on return to IDLE, so a new frame may start the cycle after in_last.
REQ-020 SHALL hold out_data and out_last stable while out_valid && !out_ready, and accept no input during that time.
REQ-021 SHALL keep the next frame's first byte out of the CRC of the preceding frame.

Reset
REQ-022 SHALL, on rst, force the FSM to IDLE, CRC to FFFFFFFF, and drive out_valid, out_last, status_valid, crc_ok, runt and counters to 0.
REQ-023 SHALL, on rst mid-frame, discard the frame with no status pulse; rst has priority over any simultaneous transfer.

Configuration
REQ-024 SHALL, with CRC_32_BYTE_CHECKER_STATS_EN defined, increment frame_cnt on every status pulse and err_cnt on every pulse with crc_ok=0; both saturate at FFFFFFFF.
REQ-025 SHALL, without the macro, omit the counters and their ports entirely.

Structure
REQ-026 SHALL take CRC_POLY, CRC_INITIAL_VALUE, the bit-reverse helper, the invert-reverse helper and the FSM state enum typedef from the shared crc_32_byte package.
REQ-027 SHALL instantiate a combinational sub-module crc_32_byte_update (32-bit crc in plus byte in, 32-bit crc out), also reusable by the generator.

Verification
REQ-028 SHALL cover: "123456789" followed by 26 39 F4 CB, out_ready=1 -> 9 bytes out, out_last on "9", crc_ok=1, runt=0.
REQ-029 SHALL cover: same frame with the last FCS byte CA -> payload still output, status pulse with crc_ok=0.
REQ-030 SHALL cover: 3-byte frame AA BB CC(last) -> no out_valid, status_valid with runt=1, crc_ok=0.
REQ-031 SHALL cover: out_ready held 0 for 5 cycles mid-frame -> in_ready=0, out_data stable, final crc_ok=1.
REQ-032 SHALL cover: rst asserted after 6 bytes, then a clean frame -> no status for the aborted frame, clean frame crc_ok=1.
REQ-033 SHALL cover, with STATS_EN: 2 good frames plus 1 bad frame back-to-back -> frame_cnt=3, err_cnt=1.
